// File: rtl/ov7670_config_sequencer.sv
// ov7670_config_sequencer: walks a register/value table and feeds it to the SCCB controller
module ov7670_config_sequencer #(
  parameter int MAIN_CLOCK_FREQUENCY = 27_000_000,
  parameter logic [6:0] DEVICE_ADDR = 7'h21,
  parameter int ROM_ADDR_WIDTH = 8,
  parameter int DELAY_MS = 10,
  parameter int INTER_WRITE_CYCLES = 64,
  parameter int TIMEOUT_CYCLES = 2_700_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  input  logic [15:0]               rom_data,
  input  logic                      i2c_init_done,
  output logic [6:0]                i2c_device_addr,
  output logic [7:0]                i2c_data_in,
  output logic                      i2c_store_data,
  output logic                      i2c_send_data,
  input  logic                      i2c_send_complete,
  output logic                      busy,
  output logic                      config_done,
  output logic                      config_error,
  output logic [ROM_ADDR_WIDTH-1:0] entry_index
);
  localparam longint DELAY_CYCLES = longint'(DELAY_MS) * longint'(MAIN_CLOCK_FREQUENCY / 1000);
  localparam longint MAX_DT = DELAY_CYCLES > longint'(TIMEOUT_CYCLES) ? DELAY_CYCLES : longint'(TIMEOUT_CYCLES);
  localparam longint MAX_CNT = MAX_DT > longint'(INTER_WRITE_CYCLES) ? MAX_DT : longint'(INTER_WRITE_CYCLES);
  localparam int CW = $clog2(MAX_CNT + 2);
  localparam logic [CW-1:0] DELAY_LAST = CW'(DELAY_CYCLES > 0 ? DELAY_CYCLES - 1 : 0);
  localparam logic [CW-1:0] INTER_LAST = CW'(INTER_WRITE_CYCLES > 0 ? INTER_WRITE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] TMO_HIT = CW'(TIMEOUT_CYCLES > 1 ? TIMEOUT_CYCLES - 2 : 0);
  typedef enum logic [3:0] {
    IDLE, WAIT_READY, FETCH, DECODE, STORE_REG, STORE_VAL, GAP, SEND,
    WAIT_DONE, INTER_DELAY, DELAY, ADVANCE, DONE, ERROR
  } state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [7:0] val_q;
  logic prev_complete;
  logic done_edge;
  assign done_edge = i2c_send_complete & ~prev_complete;
  assign i2c_device_addr = DEVICE_ADDR;
  always_ff @(posedge clk) begin
    prev_complete <= i2c_send_complete;
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      val_q <= '0;
      prev_complete <= 1'b0;
      rom_addr <= '0;
      entry_index <= '0;
      i2c_data_in <= '0;
      i2c_store_data <= 1'b0;
      i2c_send_data <= 1'b0;
      busy <= 1'b0;
      config_done <= 1'b0;
      config_error <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= WAIT_READY;
          config_done <= 1'b0;
          config_error <= 1'b0;
          rom_addr <= '0;
          entry_index <= '0;
          busy <= 1'b1;
        end
        WAIT_READY: if (i2c_init_done) state <= FETCH;
        FETCH: state <= DECODE;
        DECODE: if (rom_data == 16'hFFFF) begin
          state <= DONE;
          config_done <= 1'b1;
          busy <= 1'b0;
        end else if (rom_data == 16'hFFF0) begin
          state <= DELAY;
          cnt <= '0;
        end else begin
          state <= STORE_REG;
          i2c_data_in <= rom_data[15:8];
          val_q <= rom_data[7:0];
          i2c_store_data <= 1'b1;
        end
        STORE_REG: begin
          state <= STORE_VAL;
          i2c_data_in <= val_q;
        end
        STORE_VAL: begin
          state <= GAP;
          i2c_store_data <= 1'b0;
        end
        GAP: begin
          state <= SEND;
          i2c_send_data <= 1'b1;
        end
        SEND: begin
          state <= WAIT_DONE;
          i2c_send_data <= 1'b0;
          cnt <= '0;
        end
        WAIT_DONE: if (done_edge) begin
          state <= INTER_DELAY;
          cnt <= '0;
        end else if (cnt == TMO_HIT) begin
          state <= ERROR;
          config_error <= 1'b1;
          busy <= 1'b0;
        end else cnt <= cnt + 1'b1;
        INTER_DELAY: if (cnt == INTER_LAST) state <= ADVANCE; else cnt <= cnt + 1'b1;
        DELAY: if (cnt == DELAY_LAST) state <= ADVANCE; else cnt <= cnt + 1'b1;
        ADVANCE: if (&rom_addr) begin
          state <= DONE;
          config_done <= 1'b1;
          busy <= 1'b0;
        end else begin
          state <= FETCH;
          rom_addr <= rom_addr + 1'b1;
          entry_index <= entry_index + 1'b1;
        end
        DONE, ERROR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// tb_ov7670_config_sequencer: scoreboard bench with table-walk reference model and controller model
module tb_ov7670_config_sequencer;
  localparam int AW = 2;
  localparam int FREQ = 100_000;
  localparam int DMS = 2;
  localparam int DLY = DMS * (FREQ / 1000);
  localparam int INTER = 8;
  localparam int TMO = 1000;
  localparam int K_REG = 0, K_VAL = 1, K_SEND = 2, K_DONE = 3, K_ERR = 4;
  typedef struct {int kind; int val; int gap;} ev_t;
  logic clk = 1'b0;
  logic rst, start, i2c_init_done, i2c_send_complete;
  logic [AW-1:0] rom_addr, entry_index;
  logic [15:0] rom_data;
  logic [6:0] i2c_device_addr;
  logic [7:0] i2c_data_in;
  logic i2c_store_data, i2c_send_data, busy, config_done, config_error;
  logic [15:0] rom [4];
  ev_t sb[$];
  int checks = 0, errors = 0, cyc = 0, n_strobes = 0, n_sends = 0;
  int ctrl_lat = 10, ctrl_hang = -1, exp_idx = 0;
  bit exp_done = 1'b0;
  ov7670_config_sequencer #(
    .MAIN_CLOCK_FREQUENCY(FREQ), .DEVICE_ADDR(7'h21), .ROM_ADDR_WIDTH(AW),
    .DELAY_MS(DMS), .INTER_WRITE_CYCLES(INTER), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .i2c_init_done(i2c_init_done), .i2c_device_addr(i2c_device_addr), .i2c_data_in(i2c_data_in),
    .i2c_store_data(i2c_store_data), .i2c_send_data(i2c_send_data),
    .i2c_send_complete(i2c_send_complete), .busy(busy), .config_done(config_done),
    .config_error(config_error), .entry_index(entry_index)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [15:0] rand_write();
    return {8'($urandom_range(0, 239)), 8'($urandom_range(0, 255))};
  endfunction
  initial begin
    logic [AW-1:0] a;
    a = '0;
    rom_data = '0;
    forever begin
      @(negedge clk);
      a = rom_addr;
      @(posedge clk);
      #1 rom_data = rom[a];
    end
  end
  initial begin
    int cd, nsend;
    cd = 0;
    nsend = 0;
    i2c_send_complete = 1'b0;
    forever begin
      @(negedge clk);
      i2c_send_complete = 1'b0;
      if (rst === 1'b1) cd = 0;
      else if (i2c_send_data === 1'b1) begin
        if (nsend != ctrl_hang) cd = ctrl_lat;
        nsend++;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) i2c_send_complete = 1'b1;
      end
      if (busy !== 1'b1) nsend = 0;
    end
  end
  initial begin
    int last_reg, last_send, h, cls, code;
    logic done_q, err_q;
    ev_t e;
    last_reg = 0;
    last_send = 0;
    h = 0;
    done_q = 1'b0;
    err_q = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      code = (i2c_store_data === 1'b1 ? 1 : 0) + (i2c_send_data === 1'b1 ? 2 : 0);
      if (code == 3) check("strobe_overlap", {i2c_store_data, i2c_send_data}, 2'b00);
      if (code != 0 || (config_done === 1'b1 && !done_q) || (config_error === 1'b1 && !err_q)) begin
        cls = code == 1 ? 0 : code == 2 ? K_SEND : config_done === 1'b1 ? K_DONE : K_ERR;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", cls, cyc);
        end else begin
          e = sb.pop_front();
          check("event_kind", cls, e.kind == K_VAL ? 0 : e.kind == K_REG ? 0 : e.kind);
          if (cls == 0) begin
            n_strobes++;
            check("store_byte", i2c_data_in, e.val);
            check("device_addr", i2c_device_addr, 7'h21);
            if (e.kind == K_REG) begin
              if (e.gap >= 0) check("write_spacing", cyc - last_reg, e.gap);
              last_reg = cyc;
            end
          end else if (cls == K_SEND) begin
            n_strobes++;
            n_sends++;
            check("send_framing", h, 6'b010100);
            last_send = cyc;
          end else if (cls == K_DONE) begin
            check("done_index", entry_index, e.val);
            check("done_busy", busy, 0);
          end else begin
            check("error_index", entry_index, e.val);
            check("timeout_cycles", cyc - last_send, e.gap);
            check("error_not_done", config_done, 0);
          end
        end
      end
      h = ((h << 2) | code) & 6'h3F;
      done_q = config_done === 1'b1;
      err_q = config_error === 1'b1;
    end
  end
  task automatic build(input int lat, input int hang);
    int extra, wr;
    bit first;
    extra = 0;
    wr = 0;
    first = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (rom[i] == 16'hFFFF) begin
        sb.push_back('{K_DONE, i, -1});
        exp_idx = i;
        exp_done = 1'b1;
        return;
      end
      if (rom[i] == 16'hFFF0) begin
        extra += DLY + 3;
        continue;
      end
      sb.push_back('{K_REG, int'(rom[i][15:8]), first ? -1 : lat + INTER + 7 + extra});
      sb.push_back('{K_VAL, int'(rom[i][7:0]), -1});
      sb.push_back('{K_SEND, 0, -1});
      if (wr == hang) begin
        sb.push_back('{K_ERR, i, TMO});
        exp_idx = i;
        exp_done = 1'b0;
        return;
      end
      first = 1'b0;
      extra = 0;
      wr++;
    end
    sb.push_back('{K_DONE, 3, -1});
    exp_idx = 3;
    exp_done = 1'b1;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_rom_addr"}, rom_addr, 0);
    check({tag, "_entry_index"}, entry_index, 0);
    check({tag, "_data_in"}, i2c_data_in, 0);
    check({tag, "_store"}, i2c_store_data, 0);
    check({tag, "_send"}, i2c_send_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, config_done, 0);
    check({tag, "_error"}, config_error, 0);
  endtask
  task automatic run(input int lat, input int hang, input int rdy_wait, input bit poke);
    int n, s0;
    build(lat, hang);
    ctrl_lat = lat;
    ctrl_hang = hang;
    i2c_init_done = rdy_wait == 0;
    s0 = n_strobes;
    pulse_start();
    if (rdy_wait > 0) begin
      repeat (rdy_wait) @(negedge clk);
      check("strobes_before_ready", n_strobes - s0, 0);
      check("busy_while_not_ready", busy, 1);
      i2c_init_done = 1'b1;
    end
    if (poke) begin
      repeat (150) @(negedge clk);
      check("busy_before_poke", busy, 1);
      pulse_start();
    end
    n = 0;
    while (!(config_done === 1'b1 || config_error === 1'b1) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("run_finished_in_budget", n < 20000, 1);
    repeat (30) @(negedge clk);
    check("all_events_seen", sb.size(), 0);
    check("end_busy", busy, 0);
    check("end_done", config_done, exp_done);
    check("end_error", config_error, !exp_done);
    check("end_rom_addr", rom_addr, exp_idx);
    check("end_entry_index", entry_index, exp_idx);
    sb.delete();
  endtask
  initial begin
    int n, s0;
    rst = 1'b1;
    start = 1'b0;
    i2c_init_done = 1'b0;
    for (int i = 0; i < 4; i++) rom[i] = 16'hFFFF;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rom[0] = 16'h1280; rom[1] = 16'hFFF0; rom[2] = 16'h1101; rom[3] = 16'hFFFF;
    run(100, -1, 0, 1'b0);
    rom[0] = rand_write(); rom[1] = 16'hFFF0; rom[2] = rand_write(); rom[3] = 16'hFFFF;
    run($urandom_range(5, 120), -1, 500, 1'b0);
    for (int i = 0; i < 3; i++) rom[i] = rand_write();
    rom[3] = 16'hFFFF;
    run(50, 1, 0, 1'b0);
    for (int i = 0; i < 4; i++) rom[i] = rand_write();
    run($urandom_range(20, 120), -1, 0, 1'b1);
    for (int i = 0; i < 3; i++) rom[i] = rand_write();
    rom[3] = 16'hFFFF;
    build(100, -1);
    ctrl_lat = 100;
    ctrl_hang = -1;
    i2c_init_done = 1'b1;
    s0 = n_sends;
    pulse_start();
    n = 0;
    while (n_sends == s0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("first_send_seen", n_sends - s0, 1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("midrun_reset");
    rst = 1'b0;
    sb.delete();
    repeat (150) @(negedge clk);
    run(60, -1, 0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        n = $urandom_range(0, 9);
        rom[i] = n == 0 ? 16'hFFFF : n == 1 ? 16'hFFF0 : rand_write();
      end
      run($urandom_range(1, 150), -1, 0, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
